// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the IF/ID boundary and its bench.
//   DEF_DATA_W   : default width of the pc and instruction fields
//   DEF_NOP_INST : instruction word shown when no entry is held (sll $0,$0,0)
//   occ_state_e  : buffer occupancy, which is also the FSM state
//   fetch_beat_t : one {pc, inst} beat at the default width
package mips_pkg;

  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } fetch_beat_t;

endpackage

// File: rtl/mips_if_id_buffer_if.sv
// mips_if_id_buffer_if: fetch-side and decode-side handshake bundle.
//   Fetch side : if_valid, if_ready, if_pc, if_inst, flush
//   Decode side: id_valid, id_ready, id_pc, id_inst, id_pc_plus4
// Handshake rule for both sides: a beat transfers at a rising clk edge where
// valid and ready are both 1; valid must not depend on ready, and the
// producer holds its data stable while valid=1 and ready=0.
// Modports: slave = the buffer's view, master = the fetch/decode view.
interface mips_if_id_buffer_if #(
  parameter int DATA_W = 32
) ();

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
  logic [DATA_W-1:0] id_pc_plus4;

  modport slave (
    input  if_valid, if_pc, if_inst, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_pc_plus4
  );

  modport master (
    output if_valid, if_pc, if_inst, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_pc_plus4
  );

endinterface

// File: rtl/mips_skid_slot.sv
// mips_skid_slot: one registered {pc, inst} entry.
//   i_load  : capture i_pc/i_inst (wins over i_clear)
//   i_clear : replace the instruction with NOP_INST, keep the pc
//   o_pc, o_inst : registered contents
// Reset: asynchronous active-high, pc=0, inst=NOP_INST.
module mips_skid_slot #(
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_inst
);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_inst <= NOP_INST;
    end else if (i_load) begin
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end else if (i_clear) begin
      r_inst <= NOP_INST;
    end
  end

  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/mips_if_id_buffer.sv
// mips_if_id_buffer: IF/ID pipeline boundary, a 2-entry in-order skid buffer.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus (slave) : fetch handshake (if_*), flush, decode handshake (id_*)
//   o_state     : current occupancy state (EMPTY/ONE/FULL) for observation
// Optional macro IF_ID_PERF_CNT_EN adds stall_cnt and flush_cnt outputs.
// The head slot drives id_pc/id_inst directly; the tail slot only holds the
// second beat while decode stalls. if_ready decodes the registered state, so
// there is no combinational path from id_ready to if_ready.
module mips_if_id_buffer
  import mips_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_if_id_buffer_if.slave   bus,
  output occ_state_e           o_state
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  occ_state_e r_state;
  occ_state_e w_next_state;

  logic w_if_ready;
  logic w_id_valid;
  logic w_push;
  logic w_pop;

  logic w_head_load;
  logic w_head_clear;
  logic w_head_from_tail;
  logic w_tail_load;

  logic [DATA_W-1:0] w_head_pc_in;
  logic [DATA_W-1:0] w_head_inst_in;
  logic [DATA_W-1:0] w_head_pc;
  logic [DATA_W-1:0] w_head_inst;
  logic [DATA_W-1:0] w_tail_pc;
  logic [DATA_W-1:0] w_tail_inst;

  assign w_if_ready = (r_state != ST_FULL);
  assign w_id_valid = (r_state != ST_EMPTY);
  assign w_push     = bus.if_valid & w_if_ready;
  assign w_pop      = w_id_valid & bus.id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and slot controls. Flush overrides everything: the incoming
  // beat is dropped and the head instruction reverts to NOP.
  always_comb begin
    w_next_state     = r_state;
    w_head_load      = 1'b0;
    w_head_clear     = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_load      = 1'b0;
    if (bus.flush) begin
      w_next_state = ST_EMPTY;
      w_head_clear = 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_next_state = ST_ONE;
            w_head_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_head_load = 1'b1;
          end else if (w_push) begin
            w_next_state = ST_FULL;
            w_tail_load  = 1'b1;
          end else if (w_pop) begin
            w_next_state = ST_EMPTY;
            w_head_clear = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_next_state     = ST_ONE;
            w_head_load      = 1'b1;
            w_head_from_tail = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_head_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_head_pc_in   = w_head_from_tail ? w_tail_pc   : bus.if_pc;
  assign w_head_inst_in = w_head_from_tail ? w_tail_inst : bus.if_inst;

  mips_skid_slot #(
    .DATA_W   (DATA_W),
    .NOP_INST (NOP_INST)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_head_load),
    .i_clear (w_head_clear),
    .i_pc    (w_head_pc_in),
    .i_inst  (w_head_inst_in),
    .o_pc    (w_head_pc),
    .o_inst  (w_head_inst)
  );

  // Tail contents are only meaningful in FULL, so it is never cleared.
  mips_skid_slot #(
    .DATA_W   (DATA_W),
    .NOP_INST (NOP_INST)
  ) u_tail (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tail_load),
    .i_clear (1'b0),
    .i_pc    (bus.if_pc),
    .i_inst  (bus.if_inst),
    .o_pc    (w_tail_pc),
    .o_inst  (w_tail_inst)
  );

  assign bus.if_ready    = w_if_ready;
  assign bus.id_valid    = w_id_valid;
  assign bus.id_pc       = w_head_pc;
  assign bus.id_inst     = w_head_inst;
  assign bus.id_pc_plus4 = w_head_pc + DATA_W'(4);
  assign o_state         = r_state;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // A flush is counted only when it actually discards something: a held
  // entry or a beat fetch is presenting in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.if_valid && !w_if_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (bus.flush && ((r_state != ST_EMPTY) || bus.if_valid)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_mips_if_id_buffer.sv
// Bench for mips_if_id_buffer. Inputs change 1 time unit after the rising
// edge; the monitor samples at the falling edge and the driver books pushes
// 2 units after the falling edge, so a pop is checked before any flush
// bookkeeping of the same cycle. Define IF_ID_PERF_CNT_EN to also cover the
// performance counters.
module tb_mips_if_id_buffer;
  import mips_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  occ_state_e state;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  mips_if_id_buffer_if #(.DATA_W(W)) bus ();

  mips_if_id_buffer #(
    .DATA_W   (W),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_state   (state)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat decode takes must be the oldest accepted beat.
  always @(negedge clk) begin
    if (!rst && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got pc %h with nothing expected at %0t", bus.id_pc, $time);
      end else begin
        fetch_beat_t e;
        e = exp_q.pop_front();
        check("beat_pc", bus.id_pc, e.pc);
        check("beat_inst", bus.id_inst, e.inst);
        check("beat_pc_plus4", bus.id_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] pc, input logic [W-1:0] inst,
                       input logic rdy, input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.id_ready = rdy;
    bus.flush    = fl;
  endtask

  // Called 1 unit after a rising edge; returns 1 unit after the next one.
  task automatic step();
    fetch_beat_t b;
    @(negedge clk);
    #2;
    if (bus.flush) begin
      exp_q.delete();
    end else if (bus.if_valid && bus.if_ready) begin
      b.pc   = bus.if_pc;
      b.inst = bus.if_inst;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_pc", bus.id_pc, 32'h0);
    check("rst_id_inst", bus.id_inst, 32'h0000_0000);
    check("rst_pc_plus4", bus.id_pc_plus4, 32'h4);
    check("rst_if_ready", {31'd0, bus.if_ready}, 32'd1);
    check("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;

    // Single beat, latency 1
    drive(1'b1, 32'h0, 32'h2008_0005, 1'b1, 1'b0);
    check("pre_push_inst", bus.id_inst, 32'h0000_0000);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("single_valid", {31'd0, bus.id_valid}, 32'd1);
    check("single_pc_plus4", bus.id_pc_plus4, 32'h4);
    step();
    check("single_empty", {31'd0, bus.id_valid}, 32'd0);

    // Stall fill
    drive(1'b1, 32'h4, 32'h0000_0004, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8, 32'h0000_0008, 1'b0, 1'b0);
    step();
    check("fill_if_ready_low", {31'd0, bus.if_ready}, 32'd0);
    drive(1'b1, 32'hC, 32'h0000_000C, 1'b0, 1'b0);
    step();
    check("fill_held_state", {30'd0, state}, 32'd2);
    drive(1'b1, 32'hC, 32'h0000_000C, 1'b1, 1'b0);
    step();
    check("drain_valid_1", {31'd0, bus.id_valid}, 32'd1);
    check("drain_if_ready", {31'd0, bus.if_ready}, 32'd1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_valid_2", {31'd0, bus.id_valid}, 32'd1);
    check("drain_head_c", bus.id_pc, 32'hC);
    step();
    check("drain_empty", {31'd0, bus.id_valid}, 32'd0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'h0100_0000 + 32'(i), 1'b1, 1'b0);
      step();
      check("stream_if_ready", {31'd0, bus.if_ready}, 32'd1);
      check("stream_state", {30'd0, state}, 32'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    // Flush with full buffer plus incoming beat
    drive(1'b1, 32'h10, 32'h0000_0010, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h14, 32'h0000_0014, 1'b0, 1'b0);
    step();
    check("flush_pre_full", {30'd0, state}, 32'd2);
    drive(1'b1, 32'h18, 32'h0000_0018, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("flush_valid", {31'd0, bus.id_valid}, 32'd0);
    check("flush_if_ready", {31'd0, bus.if_ready}, 32'd1);
    check("flush_nop", bus.id_inst, 32'h0000_0000);
    drive(1'b1, 32'h40, 32'h0800_0010, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_flush_pc", bus.id_pc, 32'h40);
    step();

    // pc+4 wrap, then async reset while FULL
    drive(1'b1, 32'hFFFF_FFFC, 32'h03E0_0008, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h100, 32'h0000_0100, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("wrap_pc_plus4", bus.id_pc_plus4, 32'h0);
    check("wrap_full", {30'd0, state}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("async_id_inst", bus.id_inst, 32'h0000_0000);
    check("async_id_pc", bus.id_pc, 32'h0);
    check("async_if_ready", {31'd0, bus.if_ready}, 32'd1);
    exp_q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, bus.id_valid}, 32'd0);

`ifdef IF_ID_PERF_CNT_EN
    drive(1'b1, 32'h200, 32'h0000_0200, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h204, 32'h0000_0204, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h208, 32'h0000_0208, 1'b0, 1'b0);
    repeat (5) step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_cnt", stall_cnt, 32'd5);
    check("flush_cnt", flush_cnt, 32'd1);
`endif

    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
